// File: rtl/mmi_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the mmi bus arbiter slice.
// Holds the RAM-bus field widths, the arbiter FSM encoding, the default
// forced-completion read word and a small one-hot helper.
package mmi_pkg;

    localparam int unsigned MMI_ADDR_W = 3;
    localparam int unsigned MMI_DATA_W = 32;
    localparam int unsigned MMI_STRB_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    typedef enum logic [1:0] {
        StIdle = S_IDLE,
        StBusy = S_BUSY,
        StGap  = S_GAP
    } state_e;

    localparam logic [MMI_DATA_W-1:0] MMI_ERR_WORD = 32'hDEAD_BEEF;

    // Requester index to one-hot grant vector.
    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mmi_rr_pick.sv
`timescale 1ns/1ps
// Combinational two-way round-robin picker with a lock mask.
// Ports:
//   valid_i   - request vector, bit N for requester N
//   last_i    - requester granted most recently (loses a tie)
//   lock_en_i - a lock owner exists; only its request is considered
//   lock_id_i - lock owner index
//   grant_o   - one-hot winner, 0 when nothing eligible
module mmi_rr_pick
    import mmi_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_i,
    input  logic       lock_en_i,
    input  logic       lock_id_i,
    output logic [1:0] grant_o
);

    logic [1:0] masked;

    always_comb begin
        masked = valid_i;
        if (lock_en_i) begin
            masked = valid_i & id_to_onehot(lock_id_i);
        end
        grant_o = masked;
        // Tie: the requester that did not go last wins.
        if (masked == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mmi_bus_arbiter.sv
`timescale 1ns/1ps
// Two-requester arbiter in front of the mmi_top RAM-bus slave port.
// Requester 0 is the core data bus, requester 1 the coprocessor/DMA sequencer.
// Accesses are serialised round-robin; a requester may lock the port across a
// multi-register sequence, and a hung access is force-completed with ERR_WORD.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   mN_valid/lock/wstrb/...   - requester N request side (N = 0, 1)
//   mN_ready, mN_rdata        - requester N one-cycle completion and read data
//   mmi_valid/wstrb/wdata/addr - captured access towards the slave
//   mmi_ready, mmi_rdata      - slave completion and read data
//   o_grant                   - one-hot current owner (lock owner when locked)
//   o_err, o_err_id           - timeout pulse and the requester that timed out
module mmi_bus_arbiter
    import mmi_pkg::*;
#(
    parameter int unsigned           TIMEOUT_CYC = 64,
    parameter logic [MMI_DATA_W-1:0] ERR_WORD    = MMI_ERR_WORD,
    parameter int unsigned           CNT_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_lock,
    input  logic [MMI_STRB_W-1:0] m0_wstrb,
    input  logic [MMI_DATA_W-1:0] m0_wdata,
    input  logic [MMI_ADDR_W-1:0] m0_addr,
    output logic [MMI_DATA_W-1:0] m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_lock,
    input  logic [MMI_STRB_W-1:0] m1_wstrb,
    input  logic [MMI_DATA_W-1:0] m1_wdata,
    input  logic [MMI_ADDR_W-1:0] m1_addr,
    output logic [MMI_DATA_W-1:0] m1_rdata,
    output logic                  mmi_valid,
    input  logic                  mmi_ready,
    output logic [MMI_STRB_W-1:0] mmi_wstrb,
    output logic [MMI_DATA_W-1:0] mmi_wdata,
    output logic [MMI_ADDR_W-1:0] mmi_addr,
    input  logic [MMI_DATA_W-1:0] mmi_rdata,
    output logic [1:0]            o_grant,
    output logic                  o_err,
    output logic                  o_err_id
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYC - 1);

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  lock_en_q, lock_en_d;
    logic                  lock_id_q, lock_id_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MMI_STRB_W-1:0] wstrb_q, wstrb_d;
    logic [MMI_DATA_W-1:0] wdata_q, wdata_d;
    logic [MMI_ADDR_W-1:0] addr_q, addr_d;
    logic                  err_id_q, err_id_d;

    logic [1:0]            pick_gnt;
    logic                  gid;
    logic                  timeout;
    logic                  done;
    logic [MMI_DATA_W-1:0] rsp_data;

    mmi_rr_pick u_pick (
        .valid_i   ({m1_valid, m0_valid}),
        .last_i    (last_q),
        .lock_en_i (lock_en_q),
        .lock_id_i (lock_id_q),
        .grant_o   (pick_gnt)
    );

    assign gid       = gnt_q[1];
    assign mmi_wstrb = wstrb_q;
    assign mmi_wdata = wdata_q;
    assign mmi_addr  = addr_q;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        lock_en_d = lock_en_q;
        lock_id_d = lock_id_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        err_id_d  = err_id_q;
        mmi_valid = 1'b0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        o_err     = 1'b0;
        o_err_id  = err_id_q;
        o_grant   = lock_en_q ? id_to_onehot(lock_id_q) : 2'b00;
        timeout   = 1'b0;
        done      = 1'b0;
        rsp_data  = mmi_rdata;

        unique case (state_q)
            StIdle: begin
                if (pick_gnt != 2'b00) begin
                    gnt_d   = pick_gnt;
                    last_d  = pick_gnt[1];
                    cnt_d   = '0;
                    wstrb_d = pick_gnt[1] ? m1_wstrb : m0_wstrb;
                    wdata_d = pick_gnt[1] ? m1_wdata : m0_wdata;
                    addr_d  = pick_gnt[1] ? m1_addr : m0_addr;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                mmi_valid = 1'b1;
                o_grant   = gnt_q;
                // A slave ready in the final cycle still wins over the timeout.
                timeout   = !mmi_ready && (cnt_q == CntLast);
                done      = mmi_ready || timeout;
                if (mmi_ready) begin
                    lock_en_d = gid ? m1_lock : m0_lock;
                    lock_id_d = gid;
                    state_d   = StGap;
                end else if (timeout) begin
                    o_err     = 1'b1;
                    o_err_id  = gid;
                    err_id_d  = gid;
                    lock_en_d = 1'b0;
                    rsp_data  = ERR_WORD;
                    state_d   = StGap;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (done) begin
                    m0_ready = !gid;
                    m1_ready = gid;
                    m0_rdata = gid ? '0 : rsp_data;
                    m1_rdata = gid ? rsp_data : '0;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            lock_en_q <= 1'b0;
            lock_id_q <= 1'b0;
            gnt_q     <= 2'b00;
            cnt_q     <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            err_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            lock_en_q <= lock_en_d;
            lock_id_q <= lock_id_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            err_id_q  <= err_id_d;
        end
    end

endmodule

// File: tb/tb_mmi_bus_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mmi_bus_arbiter: a cycle table for arbitration and
// locking, plus hand-written sequences for timeout and reset corner cases.
module tb_mmi_bus_arbiter;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m0_ready, m0_lock;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_wdata, m0_rdata;
    logic [2:0]  m0_addr;
    logic        m1_valid, m1_ready, m1_lock;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_wdata, m1_rdata;
    logic [2:0]  m1_addr;
    logic        mmi_valid, mmi_ready;
    logic [3:0]  mmi_wstrb;
    logic [31:0] mmi_wdata, mmi_rdata;
    logic [2:0]  mmi_addr;
    logic [1:0]  o_grant;
    logic        o_err, o_err_id;

    int n_chk = 0;
    int n_err = 0;
    logic exp_err_id = 1'b0;

    always #5 clk = ~clk;

    mmi_bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_valid  (m0_valid),
        .m0_ready  (m0_ready),
        .m0_lock   (m0_lock),
        .m0_wstrb  (m0_wstrb),
        .m0_wdata  (m0_wdata),
        .m0_addr   (m0_addr),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_ready  (m1_ready),
        .m1_lock   (m1_lock),
        .m1_wstrb  (m1_wstrb),
        .m1_wdata  (m1_wdata),
        .m1_addr   (m1_addr),
        .m1_rdata  (m1_rdata),
        .mmi_valid (mmi_valid),
        .mmi_ready (mmi_ready),
        .mmi_wstrb (mmi_wstrb),
        .mmi_wdata (mmi_wdata),
        .mmi_addr  (mmi_addr),
        .mmi_rdata (mmi_rdata),
        .o_grant   (o_grant),
        .o_err     (o_err),
        .o_err_id  (o_err_id)
    );

    typedef struct {
        logic [31:0] v0, l0, a0, d0, s0;
        logic [31:0] v1, l1, a1, d1, s1;
        logic [31:0] rdy, rdata;
        logic [31:0] e_mv, e_gnt, e_r0, e_rd0, e_r1, e_rd1, e_addr, e_wdata, e_strb;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t mk(
        input logic [31:0] v0, l0, a0, d0, s0, v1, l1, a1, d1, s1, rdy, rdata,
        input logic [31:0] e_mv, e_gnt, e_r0, e_rd0, e_r1, e_rd1, e_addr, e_wdata, e_strb);
        vec_t v;
        v.v0 = v0; v.l0 = l0; v.a0 = a0; v.d0 = d0; v.s0 = s0;
        v.v1 = v1; v.l1 = l1; v.a1 = a1; v.d1 = d1; v.s1 = s1;
        v.rdy = rdy; v.rdata = rdata;
        v.e_mv = e_mv; v.e_gnt = e_gnt; v.e_r0 = e_r0; v.e_rd0 = e_rd0;
        v.e_r1 = e_r1; v.e_rd1 = e_rd1; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_strb = e_strb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic id, input logic v, input logic [2:0] a);
        if (id) begin
            m1_valid = v; m1_lock = 1'b0; m1_addr = a; m1_wstrb = 4'h0; m1_wdata = 32'h0;
        end else begin
            m0_valid = v; m0_lock = 1'b0; m0_addr = a; m0_wstrb = 4'h0; m0_wdata = 32'h0;
        end
    endtask

    // Access held in BUSY for TO cycles; the slave answers only in the last
    // cycle when rdy_at_end is set, otherwise the arbiter must force it.
    task automatic run_long(input logic id, input logic rdy_at_end);
        @(negedge clk);
        drive_req(id, 1'b1, 3'd2);
        mmi_ready = 1'b0;
        #2 chk("long_idle_mv", 32'(mmi_valid), 0);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            mmi_ready = rdy_at_end && (k == TO);
            mmi_rdata = 32'h1234_5678;
            #2;
            if (k < TO) begin
                if (k == 1 || k == TO - 1) begin
                    chk($sformatf("long_k%0d_mv", k), 32'(mmi_valid), 1);
                    chk($sformatf("long_k%0d_rdy", k), 32'(id ? m1_ready : m0_ready), 0);
                    chk($sformatf("long_k%0d_err", k), 32'(o_err), 0);
                end
            end else begin
                chk("long_end_rdy", 32'(id ? m1_ready : m0_ready), 1);
                chk("long_end_other_rdy", 32'(id ? m0_ready : m1_ready), 0);
                chk("long_end_rdata", id ? m1_rdata : m0_rdata,
                    rdy_at_end ? 32'h1234_5678 : 32'hDEAD_BEEF);
                chk("long_end_err", 32'(o_err), rdy_at_end ? 0 : 1);
                if (!rdy_at_end) exp_err_id = id;
                chk("long_end_err_id", 32'(o_err_id), 32'(exp_err_id));
            end
        end
        @(negedge clk);
        drive_req(id, 1'b0, 3'd0);
        mmi_ready = 1'b0;
        #2;
        chk("long_gap_mv", 32'(mmi_valid), 0);
        chk("long_gap_err", 32'(o_err), 0);
        chk("long_gap_err_id", 32'(o_err_id), 32'(exp_err_id));
    endtask

    task automatic normal_access(input logic id, input logic [2:0] a, input logic [31:0] rd);
        @(negedge clk);
        drive_req(id, 1'b1, a);
        #2 chk("norm_idle_mv", 32'(mmi_valid), 0);
        @(negedge clk);
        mmi_ready = 1'b1;
        mmi_rdata = rd;
        #2;
        chk("norm_gnt", 32'(o_grant), id ? 2 : 1);
        chk("norm_rdy", 32'(id ? m1_ready : m0_ready), 1);
        chk("norm_rdata", id ? m1_rdata : m0_rdata, rd);
        chk("norm_addr", 32'(mmi_addr), 32'(a));
        chk("norm_err", 32'(o_err), 0);
        @(negedge clk);
        drive_req(id, 1'b0, 3'd0);
        mmi_ready = 1'b0;
        #2 chk("norm_gap_mv", 32'(mmi_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        m0_valid = 0; m0_lock = 0; m0_wstrb = 0; m0_wdata = 0; m0_addr = 0;
        m1_valid = 0; m1_lock = 0; m1_wstrb = 0; m1_wdata = 0; m1_addr = 0;
        mmi_ready = 0; mmi_rdata = 0;
        #1 rst = 1'b1;
        #2;
        chk("rst_mv", 32'(mmi_valid), 0);
        chk("rst_gnt", 32'(o_grant), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_err_id", 32'(o_err_id), 0);
        chk("rst_r0", 32'(m0_ready), 0);
        chk("rst_mmi_addr", 32'(mmi_addr), 0);
        @(negedge clk);
        rst = 1'b0;

        //            v0 l0 a0 d0     s0 v1 l1 a1 d1    s1 rdy rdata
        //            mv gnt r0 rd0    r1 rd1 addr wdata strb
        tbl[0]  = mk(1, 0, 1, 'h10, 0, 1, 0, 2, 'h20, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 'h10, 0, 1, 0, 2, 'h20, 0, 1, 'hAAAA0001,
                     1, 1, 1, 'hAAAA0001, 0, 0, 1, 'h10, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 2, 'h20, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0, 2, 'h20, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 0, 2, 'h20, 0, 1, 'hBBBB0002,
                     1, 2, 0, 0, 1, 'hBBBB0002, 2, 'h20, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 4, 'h40, 0, 1, 0, 5, 'h50, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 4, 'h40, 0, 1, 0, 5, 'h50, 0, 1, 'hC4,
                     1, 1, 1, 'hC4, 0, 0, 4, 'h40, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 5, 'h50, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 6, 'h60, 0, 1, 0, 5, 'h50, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 6, 'h60, 0, 1, 0, 5, 'h50, 0, 0, 0,
                     1, 2, 0, 0, 0, 0, 5, 'h50, 0);
        tbl[11] = mk(1, 0, 6, 'h60, 0, 1, 0, 5, 'h50, 0, 1, 'hD5,
                     1, 2, 0, 0, 1, 'hD5, 5, 'h50, 0);
        tbl[12] = mk(1, 0, 6, 'h60, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 6, 'h60, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 6, 'h60, 0, 0, 0, 0, 0, 0, 1, 'hE6,
                     1, 1, 1, 'hE6, 0, 0, 6, 'h60, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 0, 3, 'hA5, 'hF, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Requester changes its data and then drops valid while BUSY.
        tbl[17] = mk(1, 0, 3, 'h0, 'h0, 0, 0, 0, 0, 0, 0, 0,
                     1, 1, 0, 0, 0, 0, 3, 'hA5, 'hF);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h5A5A,
                     1, 1, 1, 'h5A5A, 0, 0, 3, 'hA5, 'hF);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        // m1 locked run of three while m0 keeps requesting.
        tbl[20] = mk(1, 0, 7, 'h70, 0, 1, 1, 1, 'h11, 3, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 0, 7, 'h70, 0, 1, 1, 1, 'h11, 3, 1, 'hF1,
                     1, 2, 0, 0, 1, 'hF1, 1, 'h11, 3);
        tbl[22] = mk(1, 0, 7, 'h70, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[23] = mk(1, 0, 7, 'h70, 0, 1, 1, 2, 'h22, 3, 0, 0,
                     0, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[24] = mk(1, 0, 7, 'h70, 0, 1, 1, 2, 'h22, 3, 1, 'hF2,
                     1, 2, 0, 0, 1, 'hF2, 2, 'h22, 3);
        tbl[25] = mk(1, 0, 7, 'h70, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[26] = mk(1, 0, 7, 'h70, 0, 1, 0, 3, 'h33, 3, 0, 0,
                     0, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[27] = mk(1, 0, 7, 'h70, 0, 1, 0, 3, 'h33, 3, 1, 'hF3,
                     1, 2, 0, 0, 1, 'hF3, 3, 'h33, 3);
        tbl[28] = mk(1, 0, 7, 'h70, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[29] = mk(1, 0, 7, 'h70, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[30] = mk(1, 0, 7, 'h70, 0, 0, 0, 0, 0, 0, 1, 'h77,
                     1, 1, 1, 'h77, 0, 0, 7, 'h70, 0);
        tbl[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            m0_valid = tbl[i].v0[0]; m0_lock = tbl[i].l0[0]; m0_addr = tbl[i].a0[2:0];
            m0_wdata = tbl[i].d0;    m0_wstrb = tbl[i].s0[3:0];
            m1_valid = tbl[i].v1[0]; m1_lock = tbl[i].l1[0]; m1_addr = tbl[i].a1[2:0];
            m1_wdata = tbl[i].d1;    m1_wstrb = tbl[i].s1[3:0];
            mmi_ready = tbl[i].rdy[0];
            mmi_rdata = tbl[i].rdata;
            #2;
            chk($sformatf("r%0d_mv", i), 32'(mmi_valid), tbl[i].e_mv);
            chk($sformatf("r%0d_gnt", i), 32'(o_grant), tbl[i].e_gnt);
            chk($sformatf("r%0d_r0", i), 32'(m0_ready), tbl[i].e_r0);
            chk($sformatf("r%0d_rd0", i), m0_rdata, tbl[i].e_rd0);
            chk($sformatf("r%0d_r1", i), 32'(m1_ready), tbl[i].e_r1);
            chk($sformatf("r%0d_rd1", i), m1_rdata, tbl[i].e_rd1);
            chk($sformatf("r%0d_err", i), 32'(o_err), 0);
            if (tbl[i].e_mv[0]) begin
                chk($sformatf("r%0d_addr", i), 32'(mmi_addr), tbl[i].e_addr);
                chk($sformatf("r%0d_wdata", i), mmi_wdata, tbl[i].e_wdata);
                chk($sformatf("r%0d_strb", i), 32'(mmi_wstrb), tbl[i].e_strb);
            end
        end
        m0_valid = 0; m1_valid = 0; m0_lock = 0; m1_lock = 0; mmi_ready = 0;

        run_long(1'b0, 1'b1);
        run_long(1'b0, 1'b0);
        normal_access(1'b1, 3'd4, 32'hCAFE_0001);
        run_long(1'b1, 1'b0);

        // m0 goes last, then reset lands mid-BUSY; afterwards m0 must still win a tie.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 3'd5);
        @(negedge clk);
        #2 chk("pre_rst_mv", 32'(mmi_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_mv", 32'(mmi_valid), 0);
        chk("mid_rst_gnt", 32'(o_grant), 0);
        chk("mid_rst_r0", 32'(m0_ready), 0);
        chk("mid_rst_err_id", 32'(o_err_id), 0);
        @(negedge clk);
        rst = 1'b0;
        drive_req(1'b0, 1'b1, 3'd1);
        drive_req(1'b1, 1'b1, 3'd2);
        #2 chk("post_rst_idle_gnt", 32'(o_grant), 0);
        @(negedge clk);
        mmi_ready = 1'b1;
        mmi_rdata = 32'h0BAD_F00D;
        #2;
        chk("post_rst_gnt", 32'(o_grant), 1);
        chk("post_rst_r0", 32'(m0_ready), 1);
        chk("post_rst_r1", 32'(m1_ready), 0);
        chk("post_rst_rd0", m0_rdata, 32'h0BAD_F00D);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 3'd0);
        drive_req(1'b1, 1'b0, 3'd0);
        mmi_ready = 1'b0;
        #2 chk("post_rst_gap_mv", 32'(mmi_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mmi_bus_arbiter.md
Name: mmi_bus_arbiter

Overview:
- Two-requester arbiter in front of the mmi_top RAM-bus slave port. Requester 0 is the core data bus; requester 1 is the coprocessor/DMA sequencer.
- Serialises accesses to the single mmi_valid/mmi_ready port using round-robin priority.
- Lets one requester lock the port for multi-register sequences, such as a CRC init/enable/feed run.
- Completes a hung access with an error word after a bounded wait.

Parameters:
TIMEOUT_CYC, 64, cycles in BUSY without mmi_ready before forced completion (>=2)
ERR_WORD, 32'hDEAD_BEEF, read data returned on forced completion
CNT_W, $clog2(TIMEOUT_CYC), timeout counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
m0_valid  in  1  requester 0 request, held until m0_ready
m0_ready  out  1  requester 0 completion pulse, 1 cycle
m0_lock  in  1  keep grant after this access completes
m0_wstrb  in  4  byte strobes, 0 = read
m0_wdata  in  32  write data
m0_addr  in  3  register word address
m0_rdata  out  32  read data, valid with m0_ready
m1_valid, m1_ready, m1_lock, m1_wstrb, m1_wdata, m1_addr, m1_rdata: identical set for requester 1
mmi_valid  out  1  to mmi_top mmi_valid
mmi_ready  in  1  from mmi_top mmi_ready
mmi_wstrb  out  4  captured strobes
mmi_wdata  out  32  captured write data
mmi_addr  out  3  captured address
mmi_rdata  in  32  from mmi_top o_mmi_rdata
o_grant  out  2  one-hot current owner, 0 when idle and unlocked
o_err  out  1  1-cycle pulse on forced completion
o_err_id  out  1  requester that timed out, held until the next error

Behaviour:
- Reset (async): state=IDLE, last=1 so requester 0 wins first. Lock owner cleared.
- Reset values: all outputs 0, except o_err_id=0.
- FSM states: IDLE, BUSY, GAP.
- IDLE arbitration:
  - If a lock owner exists, only that owner's valid is considered. The other requester waits indefinitely.
  - Otherwise, if exactly one valid, grant it. If both valid, grant the one != last.
  - On grant: capture wstrb/wdata/addr into registers, set o_grant, set last=granted, clear counter, go to BUSY.
  - Grant latency: 1 cycle from valid to mmi_valid.
- BUSY:
  - mmi_valid=1 and mmi_* are driven from the capture registers.
  - mN_ready = mmi_ready for the granted N, combinationally. mN_rdata = mmi_rdata during that cycle, otherwise 0.
  - On mmi_ready: if the granted mN_lock=1, set lock owner=N, else clear the lock. mmi_valid drops next cycle; go to GAP.
  - Counter increments every cycle without mmi_ready. When counter==TIMEOUT_CYC-1 and still no mmi_ready:
    - assert mN_ready with mN_rdata=ERR_WORD;
    - pulse o_err and set o_err_id=N;
    - clear the lock;
    - go to GAP.
  - If mmi_ready arrives in that same cycle, it is a normal completion with no error.
- GAP: one idle cycle so requesters can drop valid. mmi_valid=0. o_grant holds the lock owner if locked, else 0. Go to IDLE.
- Throughput: one access per 3 cycles minimum (grant, BUSY with immediate ready, GAP).
- Requester dropping valid in BUSY: protocol violation. The captured access still completes; the ready pulse is still issued.
- Non-granted requester: never sees ready. Its valid/data are not sampled until granted.
- Lock with the owner idle: the arbiter stays in IDLE and the other requester is starved. This is by design; the owner must end its sequence with lock=0.
- Reset mid-BUSY: mmi_valid drops immediately and the in-flight access is abandoned. The downstream must tolerate this.

Decomposition:
- Shared package mmi_pkg:
  - MMI_ADDR_W=3, MMI_DATA_W=32, MMI_STRB_W=4;
  - state encoding localparams S_IDLE/S_BUSY/S_GAP;
  - default ERR_WORD.
- Sub-module mmi_rr_pick: combinational 2-way round-robin picker with lock mask. Inputs: valid[1:0], last, lock_en, lock_id. Output: one-hot grant.
- Everything else stays in one module.

Test Plan:
- m0 write addr=3, wstrb=4'hF, wdata=32'h0000_00A5; slave ready on the 2nd BUSY cycle -> mmi_addr=3, mmi_wdata=A5, m0_ready pulses exactly once, o_grant=2'b01 throughout BUSY.
- m0 and m1 both raise valid in the same cycle after reset -> m0 is served first, then m1. Next simultaneous pair -> m1 is served first (round-robin).
- m1 runs 3 accesses with lock=1,1,0 while m0 is valid the whole time -> m1's 3 accesses complete back-to-back, then m0 is granted.
- m0 read with slave never ready, TIMEOUT_CYC=64 -> after 64 BUSY cycles m0_ready=1, m0_rdata=32'hDEAD_BEEF, o_err pulses, o_err_id=0, then m1 is granted normally.
- Slave asserts mmi_ready exactly on cycle 64 -> normal completion with slave data and no o_err.
- Async rst asserted mid-BUSY -> mmi_valid=0 and o_grant=0 in the same cycle. After release, m0 has priority.
